// File: rtl/div16x8_if.sv
// Handshake and data bundle for the 16/8 unsigned divider.
interface div16x8_if;
  logic        st;
  logic [15:0] a;
  logic [7:0]  b;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        busy;
  logic        done;
  logic        div_zero;

  modport master (
    output st, a, b,
    input  quotient, remainder, busy, done, div_zero
  );

  modport slave (
    input  st, a, b,
    output quotient, remainder, busy, done, div_zero
  );
endinterface

// File: rtl/div16x8.sv
// div16x8: sequential restoring divider, 16-bit dividend / 8-bit divisor,
// one quotient bit per cycle.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for st; results and div_zero held
// CALC  | one restoring step per cycle, 16 cycles, busy high
// DONE  | results already latched; done pulses on the edge leaving DONE
//
// done is a registered flag set by the DONE->IDLE transition, so it is seen
// one cycle after the state enters DONE (edge N+17 for a real divide, N+1
// for divide-by-zero, where edge N accepts st).
module div16x8 #(
  parameter logic [15:0] DZ_QUOT = 16'hFFFF
) (
  input  logic clk,
  input  logic rst,
  div16x8_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic [15:0] dvd_q;   // dividend bits shift out at the top, quotient bits in at the bottom
  logic [7:0]  dvs_q;
  logic [8:0]  prem_q;
  logic [15:0] quot_q;
  logic [7:0]  rem_q;
  logic        done_q;
  logic        dz_q;

  logic [8:0]  shifted;
  logic        ge;
  logic [8:0]  prem_d;
  logic [15:0] dvd_d;

  // One restoring-division step computed from the current working registers.
  always_comb begin
    shifted = {prem_q[7:0], dvd_q[15]};
    ge      = (shifted >= {1'b0, dvs_q});
    prem_d  = ge ? (shifted - {1'b0, dvs_q}) : shifted;
    dvd_d   = {dvd_q[14:0], ge};
  end

  // Control FSM with all working and output registers; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      prem_q  <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.st) begin
            dvd_q  <= bus.a;
            dvs_q  <= bus.b;
            prem_q <= '0;
            cnt_q  <= 5'd16;
            if (bus.b == 8'd0) begin
              quot_q  <= DZ_QUOT;
              rem_q   <= 8'hFF;
              dz_q    <= 1'b1;
              state_q <= DONE;
            end else begin
              dz_q    <= 1'b0;
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          dvd_q  <= dvd_d;
          prem_q <= prem_d;
          cnt_q  <= cnt_q - 5'd1;
          if (cnt_q == 5'd1) begin
            quot_q  <= dvd_d;
            rem_q   <= prem_d[7:0];
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.quotient  = quot_q;
  assign bus.remainder = rem_q;
  assign bus.busy      = (state_q == CALC);
  assign bus.done      = done_q;
  assign bus.div_zero  = dz_q;

endmodule

// File: tb/tb_div16x8.sv
// Directed bench for div16x8: known quotient/remainder pairs, latency,
// busy length, divide-by-zero, mid-operation disturbance and reset abort.
module tb_div16x8;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fails;
  logic [15:0] prev_q;
  logic [7:0]  prev_r;

  div16x8_if bus ();

  div16x8 #(.DZ_QUOT(16'hFFFF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Start one operation and follow it to done. dist_at >= 0 re-pulses st with
  // new operands in that cycle after acceptance.
  task automatic do_op(input string tag, input logic [15:0] ta, input logic [7:0] tb,
                       input logic [15:0] eq, input logic [7:0] er, input logic edz,
                       input int elat, input int dist_at);
    int lat;
    int busy_cnt;
    int extra_done;
    bit seen;
    lat = 0; busy_cnt = 0; extra_done = 0; seen = 0;
    @(negedge clk);
    bus.st = 1'b1; bus.a = ta; bus.b = tb;
    step();
    bus.st = 1'b0;
    while (!seen && lat < 40) begin
      if (bus.done === 1'b1) begin
        seen = 1;
      end else begin
        if (bus.busy === 1'b1) busy_cnt++;
        if (lat == 5) check_val({tag, " hold_q"}, {16'd0, bus.quotient}, {16'd0, prev_q});
        if (lat == dist_at) begin
          bus.st = 1'b1; bus.a = 16'd9; bus.b = 8'd2;
        end else begin
          bus.st = 1'b0;
        end
        step();
        lat++;
      end
    end
    bus.st = 1'b0;
    check_val({tag, " latency"}, lat, elat);
    check_val({tag, " busy_cycles"}, busy_cnt, (tb != 8'd0) ? 16 : 0);
    check_val({tag, " quotient"}, {16'd0, bus.quotient}, {16'd0, eq});
    check_val({tag, " remainder"}, {24'd0, bus.remainder}, {24'd0, er});
    check_val({tag, " div_zero"}, {31'd0, bus.div_zero}, {31'd0, edz});
    for (int i = 0; i < ((dist_at >= 0) ? 20 : 2); i++) begin
      step();
      if (bus.done === 1'b1) extra_done++;
    end
    check_val({tag, " single_done"}, extra_done, 0);
    prev_q = eq;
    prev_r = er;
  endtask

  initial begin
    int lat;
    int t1;
    int t2;
    int done_cnt;
    n_checks = 0;
    n_fails  = 0;
    prev_q   = '0;
    prev_r   = '0;
    rst = 1'b0;
    bus.st = 1'b0; bus.a = '0; bus.b = '0;
    repeat (3) step();
    check_val("rst quotient", {16'd0, bus.quotient}, 0);
    check_val("rst remainder", {24'd0, bus.remainder}, 0);
    check_val("rst busy", {31'd0, bus.busy}, 0);
    check_val("rst done", {31'd0, bus.done}, 0);
    check_val("rst div_zero", {31'd0, bus.div_zero}, 0);
    rst = 1'b1;
    step();

    do_op("1000/7",   16'd1000,  8'd7,   16'd142,   8'd6, 1'b0, 17, -1);
    do_op("FFFF/FF",  16'hFFFF,  8'hFF,  16'd257,   8'd0, 1'b0, 17, -1);
    do_op("FFFF/1",   16'hFFFF,  8'd1,   16'hFFFF,  8'd0, 1'b0, 17, -1);
    do_op("5/10",     16'd5,     8'd10,  16'd0,     8'd5, 1'b0, 17, -1);
    do_op("0/3",      16'd0,     8'd3,   16'd0,     8'd0, 1'b0, 17, -1);
    do_op("1234/0",   16'd1234,  8'd0,   16'hFFFF,  8'hFF, 1'b1, 1, -1);
    do_op("60000/13", 16'd60000, 8'd13,  16'd4615,  8'd5, 1'b0, 17, -1);
    do_op("dist",     16'd1000,  8'd7,   16'd142,   8'd6, 1'b0, 17, 5);
    do_op("255/255",  16'd255,   8'd255, 16'd1,     8'd0, 1'b0, 17, -1);

    // Reset during CALC aborts with no done pulse.
    @(negedge clk);
    bus.st = 1'b1; bus.a = 16'd1000; bus.b = 8'd7;
    step();
    bus.st = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.done === 1'b1) done_cnt++;
      step();
    end
    rst = 1'b0;
    step();
    rst = 1'b1;
    check_val("abort busy", {31'd0, bus.busy}, 0);
    check_val("abort quotient", {16'd0, bus.quotient}, 0);
    check_val("abort remainder", {24'd0, bus.remainder}, 0);
    check_val("abort done", {31'd0, bus.done}, 0);
    for (int i = 0; i < 25; i++) begin
      step();
      if (bus.done === 1'b1) done_cnt++;
    end
    check_val("abort no_done", done_cnt, 0);
    prev_q = '0;
    prev_r = '0;
    do_op("after_abort", 16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, 17, -1);

    // st held high: restarts on the first IDLE cycle after DONE.
    @(negedge clk);
    bus.st = 1'b1; bus.a = 16'd100; bus.b = 8'd10;
    step();
    lat = 0; t1 = -1; t2 = -1;
    while (t2 < 0 && lat < 60) begin
      if (bus.done === 1'b1) begin
        if (t1 < 0) t1 = lat;
        else t2 = lat;
      end
      if (t2 < 0) begin
        step();
        lat++;
      end
    end
    bus.st = 1'b0;
    check_val("held_st first_done", t1, 17);
    check_val("held_st second_done", t2, 35);
    check_val("held_st quotient", {16'd0, bus.quotient}, 10);
    repeat (25) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/div16x8.md
DIV16X8 -- requirements
Module: div16x8

Interface
REQ-001 SHALL have parameter DZ_QUOT, default 16'hFFFF: the quotient reported on divide-by-zero.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port st, input, 1 bit: start request, sampled only in IDLE.
REQ-005 SHALL have port a, input, 16 bits: unsigned dividend.
REQ-006 SHALL have port b, input, 8 bits: unsigned divisor.
REQ-007 SHALL have port quotient, output reg, 16 bits: result quotient.
REQ-008 SHALL have port remainder, output reg, 8 bits: result remainder.
REQ-009 SHALL have port busy, output, 1 bit: high while in CALC.
REQ-010 SHALL have port done, output reg, 1 bit: one-cycle pulse marking valid results.
REQ-011 SHALL have port div_zero, output reg, 1 bit: high when the last accepted operation had b==0.

Function
REQ-012 SHALL implement the FSM states IDLE, CALC and DONE, one-hot or binary.
REQ-013 SHALL, in IDLE with st==1 at a clock edge, latch a and b into internal registers, clear the 9-bit partial remainder, load the 5-bit iteration counter with 16, clear div_zero, and go to CALC; if b==0, it SHALL instead go to DONE directly.
REQ-014 SHALL, in IDLE with st==0, stay in IDLE and hold all outputs.
REQ-015 SHALL perform one restoring-division step per CALC cycle, MSB of the dividend first: shift the partial remainder left, shifting in the next dividend bit; if the result is >= divisor, subtract the divisor and shift in quotient bit 1, else shift in 0.
REQ-016 SHALL use a partial remainder of 9 bits so the compare/subtract never overflows; remainder is its low 8 bits.
REQ-017 SHALL decrement the counter each CALC cycle and go to DONE on the edge that completes the 16th step.
REQ-018 SHALL update quotient and remainder only on the edge that enters DONE, so outputs hold the previous result while busy.
REQ-019 SHALL assert done for exactly one cycle in DONE, then return to IDLE unconditionally.
REQ-020 SHALL set latency to: st sampled at edge N, done high during the cycle after edge N+17 (16 CALC cycles, then DONE) for b!=0, and during the cycle after edge N+1 for b==0.
REQ-021 SHALL, for b==0, set quotient=DZ_QUOT, remainder=8'hFF and div_zero=1, with done pulsed once.
REQ-022 SHALL ignore st while in CALC or DONE; an st held high continuously restarts on the first IDLE cycle after DONE.
REQ-023 SHALL ensure no operand change on a or b after acceptance affects the running operation.
REQ-024 SHALL drive busy=1 exactly during CALC cycles.
REQ-025 SHALL guarantee quotient*b+remainder==a and remainder<b for every b!=0.

Reset
REQ-026 SHALL, with rst==0 at a clock edge, enter IDLE and set quotient=0, remainder=0, done=0, div_zero=0, busy=0, counter=0 and internal registers=0.
REQ-027 SHALL, on rst==0 mid-CALC, abort the operation with no done pulse and zero the outputs per REQ-026.
REQ-028 SHALL give rst priority over st on the same edge.
REQ-029 SHALL not cause an asynchronous output change on assertion of rst.

Verification
REQ-030 SHALL cover: a=1000, b=7, st pulse -> done after 17 edges, quotient=142, remainder=6, div_zero=0.
REQ-031 SHALL cover: a=16'hFFFF, b=8'hFF -> quotient=257, remainder=0; then a=16'hFFFF, b=1 -> quotient=16'hFFFF, remainder=0.
REQ-032 SHALL cover: a=5, b=10 -> quotient=0, remainder=5; a=0, b=3 -> quotient=0, remainder=0.
REQ-033 SHALL cover: a=1234, b=0 -> done on the 2nd edge, quotient=16'hFFFF, remainder=8'hFF, div_zero=1; the next valid operation clears div_zero.
REQ-034 SHALL cover: st re-pulsed and a/b changed at CALC cycle 5 -> ignored; the original result is correct and exactly one done pulse occurs.
REQ-035 SHALL cover: rst=0 at CALC cycle 8 -> the next cycle is IDLE, outputs are 0 and no done pulse occurs; a following st with 1000/7 yields 142 r 6.
